// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scanner: widths, blank codes and
// the hex-to-segment table (active-low, bits g..a).
package seg_scan_pkg;

    localparam int unsigned VALUE_W = 16;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned HEX_W   = SEG_W - 1;

    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
    localparam logic [SEL_W-1:0] SEL_OFF   = 4'hF;

    // Entry i holds the active-low g..a pattern for hex digit i
    localparam logic [15:0][HEX_W-1:0] HEX_TAB = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg_scan_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
    import seg_scan_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [HEX_W-1:0] seg_c
);

    assign seg_c = HEX_TAB[nibble];

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner with anti-ghost blanking,
// shadow capture of value/dp and optional leading-zero suppression.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV  = 16'd50000,
    parameter logic [15:0] BLANK_CYC = 16'd64
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic [VALUE_W-1:0] value,
    input  logic               load,
    input  logic               lz_en,
    input  logic [SEL_W-1:0]   dp,
    output logic [SEG_W-1:0]   SEG,
    output logic [SEL_W-1:0]   SEG_SEL
);

    logic [15:0]        presc;
    logic [1:0]         idx;
    logic [VALUE_W-1:0] shadow_val;
    logic [SEL_W-1:0]   shadow_dp;

    logic               wrap_c;
    logic [NIB_W-1:0]   nibble_c;
    logic [HEX_W-1:0]   hex_c;
    logic               upper_zero_c;
    logic               suppress_c;
    logic [SEG_W-1:0]   seg_nxt_c;
    logic [SEL_W-1:0]   sel_nxt_c;

    assign wrap_c   = (presc == SCAN_DIV - 16'd1);
    assign nibble_c = shadow_val[{idx, 2'b00} +: NIB_W];

    hex_to_seg u_hex (
        .nibble (nibble_c),
        .seg_c  (hex_c)
    );

    // Digit k>=1 goes dark when it and every higher nibble are zero and its dp is off
    assign upper_zero_c = ((shadow_val >> {idx, 2'b00}) == VALUE_W'(0));
    assign suppress_c   = lz_en && (idx != 2'd0) && upper_zero_c && !shadow_dp[idx];

    always_comb begin
        seg_nxt_c = SEG_BLANK;
        sel_nxt_c = SEL_OFF;
        if (presc >= BLANK_CYC) begin
            sel_nxt_c = ~(SEL_W'(1) << idx);
            if (!suppress_c) begin
                seg_nxt_c = {~shadow_dp[idx], hex_c};
            end
        end
    end

    // Outputs are computed from the pre-edge state, so a load on a digit
    // switch only becomes visible one cycle later, never mid-digit.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            presc      <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            SEG        <= SEG_BLANK;
            SEG_SEL    <= SEL_OFF;
        end else begin
            presc <= wrap_c ? 16'd0 : presc + 16'd1;
            if (wrap_c) begin
                idx <= idx + 2'd1;
            end
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp;
            end
            SEG     <= seg_nxt_c;
            SEG_SEL <= sel_nxt_c;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: a tick-count reference model predicts every
// cycle's SEG/SEG_SEL, and a monitor compares each registered output.
module tb_seg_scan;

    localparam int SD = 4;
    localparam int BC = 1;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        lz_en;
    logic [3:0]  dp;
    logic [7:0]  SEG;
    logic [3:0]  SEG_SEL;

    seg_scan #(
        .SCAN_DIV  (16'(SD)),
        .BLANK_CYC (16'(BC))
    ) dut (
        .CLK     (clk),
        .rst     (rst),
        .value   (value),
        .load    (load),
        .lz_en   (lz_en),
        .dp      (dp),
        .SEG     (SEG),
        .SEG_SEL (SEG_SEL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment codes as listed for hex digits 0..F with dp off
    logic [7:0] ref_code [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int          m_ticks;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [11:0] exp_q [$];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [11:0] predict(input logic r, input logic lz);
        int         phase;
        int         dig;
        logic [7:0] seg;
        logic [3:0] sel;
        phase = m_ticks % SD;
        dig   = (m_ticks / SD) % 4;
        seg   = 8'hFF;
        sel   = 4'hF;
        if (r && phase >= BC) begin
            sel = 4'hF;
            sel[dig] = 1'b0;
            if (lz && dig > 0 && (m_val >> (4 * dig)) == 16'd0 && !m_dp[dig])
                seg = 8'hFF;
            else begin
                seg = ref_code[(m_val >> (4 * dig)) & 16'hF];
                seg[7] = ~m_dp[dig];
            end
        end
        return {seg, sel};
    endfunction

    task automatic step(input logic r, input logic ld, input logic [15:0] v,
                        input logic [3:0] d, input logic lz);
        @(negedge clk);
        rst = r; load = ld; value = v; dp = d; lz_en = lz;
        exp_q.push_back(predict(r, lz));
        if (!r) begin
            m_ticks = 0; m_val = 16'h0; m_dp = 4'h0;
        end else begin
            m_ticks++;
            if (ld) begin
                m_val = v; m_dp = d;
            end
        end
    endtask

    task automatic idle(input int n, input logic lz);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, value, dp, lz);
    endtask

    // Monitor: every clock presents one registered output word
    always @(posedge clk) begin
        logic [11:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({SEG, SEG_SEL} !== e) begin
                bad++;
                $display("FAIL scan t=%0t seg=%h sel=%h expected seg=%h sel=%h",
                         $time, SEG, SEG_SEL, e[11:4], e[3:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int hit;
        m_ticks = 0; m_val = 0; m_dp = 0;
        rst = 1'b0; load = 1'b0; value = 16'h0; dp = 4'h0; lz_en = 1'b0;

        // Reset with a load request that must be ignored
        step(1'b0, 1'b1, 16'h1234, 4'hF, 1'b0);
        step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        idle(12, 1'b0);

        // 0x0270 without, then with, leading-zero suppression
        step(1'b1, 1'b1, 16'd624, 4'h0, 1'b0);
        idle(20, 1'b0);
        idle(20, 1'b1);

        // Zero with dp on digit 0
        step(1'b1, 1'b1, 16'h0000, 4'b0001, 1'b1);
        idle(20, 1'b1);

        // Load 0xFFFF on the wrap edge from digit 1 into digit 2
        step(1'b1, 1'b1, 16'h1200, 4'h0, 1'b0);
        hit = 0;
        for (int i = 0; i < 40 && hit == 0; i++) begin
            if (m_ticks % SD == SD - 1 && (m_ticks / SD) % 4 == 1) hit = 1;
            else idle(1, 1'b0);
        end
        total++;
        if (hit == 0) begin
            bad++;
            $display("FAIL wrap_align hit=%0d expected 1", hit);
        end
        step(1'b1, 1'b1, 16'hFFFF, 4'h0, 1'b0);
        idle(12, 1'b0);

        // Mid-period reset during digit 3
        hit = 0;
        for (int i = 0; i < 40 && hit == 0; i++) begin
            if (m_ticks % SD == 2 && (m_ticks / SD) % 4 == 3) hit = 1;
            else idle(1, 1'b0);
        end
        total++;
        if (hit == 0) begin
            bad++;
            $display("FAIL mid_reset_align hit=%0d expected 1", hit);
        end
        step(1'b0, 1'b1, 16'hABCD, 4'hF, 1'b0);
        idle(20, 1'b1);

        // Randomized traffic: sparse loads (sometimes back to back), lz toggles, rare resets
        for (int i = 0; i < 500; i++) begin
            logic [15:0] v;
            logic        r;
            v = 16'($urandom);
            if ($urandom_range(0, 2) == 0) v = v & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            r = ($urandom_range(0, 79) != 0);
            step(r, ($urandom_range(0, 5) == 0), v, 4'($urandom), 1'($urandom));
        end

        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
